chnl_tester: RTL and testbench
==============================

Name: chnl_tester

Overview:
- RIFFA user-channel loopback block with an on-chip BRAM buffer.
- Receives one complete RX transaction of C_PCI_DATA_WIDTH-bit beats into BRAM.
- Then opens a TX transaction of the same length and streams the stored beats back in order, unchanged by default.
- Connects directly to one RIFFA channel port; it is the BRAM bring-up test for the PCIe link.

Parameters:
- C_PCI_DATA_WIDTH, 128, RX/TX data beat width in bits (allowed: 32, 64, 128).
- C_DEPTH, 1024, BRAM depth in beats.
- C_ADDR_WIDTH, 10, log2(C_DEPTH).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- CHNL_RX_CLK  out  1  tied to CLK.
- CHNL_RX  in  1  RX transaction request.
- CHNL_RX_ACK  out  1  RX request acknowledge.
- CHNL_RX_LAST  in  1  ignored.
- CHNL_RX_LEN  in  32  RX length in 32-bit words.
- CHNL_RX_OFF  in  31  ignored.
- CHNL_RX_DATA  in  C_PCI_DATA_WIDTH  RX beat.
- CHNL_RX_DATA_VALID  in  1  RX beat valid.
- CHNL_RX_DATA_REN  out  1  RX beat read enable.
- CHNL_TX_CLK  out  1  tied to CLK.
- CHNL_TX  out  1  TX transaction request.
- CHNL_TX_ACK  in  1  TX request acknowledge (a 1-cycle pulse is sufficient).
- CHNL_TX_LAST  out  1  constant 1.
- CHNL_TX_LEN  out  32  TX length in 32-bit words.
- CHNL_TX_OFF  out  31  constant 0.
- CHNL_TX_DATA  out  C_PCI_DATA_WIDTH  TX beat.
- CHNL_TX_DATA_VALID  out  1  TX beat valid.
- CHNL_TX_DATA_REN  in  1  TX beat read enable.

Behaviour:
- Single clock domain (CLK). RST is synchronous and active-high; both are fixed.
- Reset (also when asserted mid-transfer): state IDLE; all outputs 0 except CHNL_TX_LAST=1; counters cleared. BRAM contents are not cleared.
- Beat size: W = C_PCI_DATA_WIDTH/32 words. Beat count N = min(ceil(LEN/W), C_DEPTH).

State machine:
- IDLE: CHNL_RX_ACK=1 combinationally while CHNL_RX=1. On a clock edge with CHNL_RX=1:
  - latch LEN;
  - if N=0, stay in IDLE;
  - otherwise go to RX and clear wr_ptr.
- RX: CHNL_RX_DATA_REN=1.
  - Each edge with CHNL_RX_DATA_VALID=1 writes CHNL_RX_DATA to BRAM[wr_ptr] and increments wr_ptr.
  - When the N-th beat is written, go to PREP. REN drops the next cycle.
  - VALID gaps of any length are tolerated.
  - Beats beyond N are not accepted.
- PREP (1 cycle): issue BRAM read of address 0; clear rd_ptr; go to TX.
- TX: CHNL_TX=1, CHNL_TX_LEN = latched LEN rounded up to a multiple of W.
  - CHNL_TX_DATA_VALID=1 from the first TX cycle, whether or not ACK has arrived.
  - A beat is transferred on each edge with VALID & CHNL_TX_DATA_REN.
- TX read pipeline:
  - BRAM read is synchronous; read address = transfer ? rd_ptr+1 : rd_ptr.
  - CHNL_TX_DATA therefore always equals BRAM[rd_ptr] with zero bubbles.
  - rd_ptr increments on each transfer.
- TX completion: after the N-th transfer, CHNL_TX and VALID deassert the next cycle and the state returns to IDLE.
- If CHNL_RX rises while in RX, PREP or TX, it is not acknowledged until IDLE.
- BRAM: single write port and single read port, C_DEPTH x C_PCI_DATA_WIDTH. Write and read never target the same address in the same cycle.

Optional Feature:
- Macro: CHNL_TESTER_INC_EN.
- Defined: each 32-bit lane of CHNL_TX_DATA is the stored lane plus 1, mod 2^32. This is combinational after the BRAM read and adds no latency.
- Undefined (default): exact echo of the stored data.

Test Plan:
- Full buffer: LEN=4096, 1024 beats with random VALID gaps (~50% duty) -> CHNL_RX_ACK seen; TX_LEN=4096; 1024 beats returned identical and in order; CHNL_TX drops after beat 1023.
- Back-pressure: REN toggled randomly during TX -> no beat duplicated or skipped; beat k equals input k.
- Short transfer: LEN=5 -> 2 beats accepted; TX_LEN=8; 2 beats echoed; then IDLE, and a second transaction works.
- Zero length: LEN=0 -> ACK; no REN; no CHNL_TX; stays IDLE.
- Reset mid-RX after 100 beats -> outputs return to reset values; a new LEN=64 transaction echoes 64 beats correctly.
- INC_EN defined: input beat 0x00000001_FFFFFFFF_00000000_7FFFFFFF -> output 0x00000002_00000000_00000001_80000000.

Source files
------------

// File: rtl/chnl_tester.sv
// chnl_tester: RIFFA channel loopback through a BRAM buffer (RX one transaction, then TX it back).
// Latency: TX opens two cycles after the last RX beat is written; TX data has zero bubbles.
// Backpressure: RX paced by CHNL_RX_DATA_VALID, TX by CHNL_TX_DATA_REN. Optional: CHNL_TESTER_INC_EN adds 1 per 32-bit lane.
module chnl_tester #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_DEPTH          = 1024,
  parameter int C_ADDR_WIDTH     = 10
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN
);

  // Words per beat and its log2, used to turn word lengths into beat counts.
  localparam int C_W   = C_PCI_DATA_WIDTH / 32;
  localparam int C_WSH = $clog2(C_W);
  // Beat counters need one extra bit so that a full buffer (C_DEPTH beats) is representable.
  localparam int CW    = C_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RX, S_PREP, S_TX} state_t;

  state_t                      state;
  logic [31:0]                 len_q;
  logic [CW-1:0]               beats;
  logic [CW-1:0]               wr_ptr;
  logic [CW-1:0]               rd_ptr;
  logic [CW-1:0]               rd_ptr_nxt;
  logic                        rx_ren;
  logic                        tx_req;
  logic                        tx_vld;
  logic [31:0]                 tx_len;

  logic [32:0]                 len_sum;
  logic [32:0]                 len_ceil;
  logic [CW-1:0]               len_beats;
  logic [31:0]                 len_round;

  logic                        wr_en;
  logic                        rd_en;
  logic                        xfer;
  logic [C_ADDR_WIDTH-1:0]     rd_addr;
  logic [C_PCI_DATA_WIDTH-1:0] rd_dat;
  logic [C_PCI_DATA_WIDTH-1:0] tx_dat;

  logic [C_PCI_DATA_WIDTH-1:0] mem [C_DEPTH];

  // Offset and last flag from the host carry no meaning for a loopback.
  logic unused_ok;
  assign unused_ok = &{1'b0, CHNL_RX_LAST, CHNL_RX_OFF, CHNL_TX_ACK};

  // Beat count of the incoming request, clamped to the buffer depth; 33-bit sum avoids overflow.
  assign len_sum   = {1'b0, CHNL_RX_LEN} + 33'(C_W - 1);
  assign len_ceil  = len_sum >> C_WSH;
  assign len_beats = (len_ceil > 33'(C_DEPTH)) ? CW'(C_DEPTH) : len_ceil[CW-1:0];

  // TX length is the requested word count rounded up to whole beats.
  assign len_round = (len_q + 32'(C_W - 1)) & ~32'(C_W - 1);

  assign wr_en      = (state == S_RX) && rx_ren && CHNL_RX_DATA_VALID;
  assign xfer       = tx_vld && CHNL_TX_DATA_REN;
  assign rd_ptr_nxt = rd_ptr + CW'(1);

  // Read one ahead on a transfer so the registered BRAM output always holds BRAM[rd_ptr].
  // Reads are only enabled in PREP/TX, so they never collide with RX writes.
  assign rd_en   = (state == S_PREP) || (state == S_TX);
  assign rd_addr = (state == S_PREP) ? '0 :
                   (xfer ? rd_ptr_nxt[C_ADDR_WIDTH-1:0] : rd_ptr[C_ADDR_WIDTH-1:0]);

  assign CHNL_RX_CLK        = CLK;
  assign CHNL_TX_CLK        = CLK;
  assign CHNL_RX_ACK        = (state == S_IDLE) && CHNL_RX;
  assign CHNL_RX_DATA_REN   = rx_ren;
  assign CHNL_TX            = tx_req;
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_LEN        = tx_len;
  assign CHNL_TX_OFF        = '0;
  assign CHNL_TX_DATA       = tx_dat;
  assign CHNL_TX_DATA_VALID = tx_vld;

  // BRAM write port: store each accepted RX beat at wr_ptr.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr[C_ADDR_WIDTH-1:0]] <= CHNL_RX_DATA;
    end
  end

  // BRAM synchronous read port.
  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

  // Output data: stored beat, optionally with every 32-bit lane incremented; zero when not valid.
  always_comb begin
    tx_dat = '0;
    if (tx_vld) begin
`ifdef CHNL_TESTER_INC_EN
      for (int i = 0; i < C_W; i++) begin
        tx_dat[i*32 +: 32] = rd_dat[i*32 +: 32] + 32'd1;
      end
`else
      tx_dat = rd_dat;
`endif
    end
  end

  // Control FSM: IDLE -> RX (collect N beats) -> PREP (prime read) -> TX (stream N beats) -> IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      len_q  <= '0;
      beats  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_ren <= 1'b0;
      tx_req <= 1'b0;
      tx_vld <= 1'b0;
      tx_len <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CHNL_RX) begin
            len_q <= CHNL_RX_LEN;
            beats <= len_beats;
            // A zero-beat request is acknowledged but nothing is moved.
            if (len_beats != '0) begin
              wr_ptr <= '0;
              rx_ren <= 1'b1;
              state  <= S_RX;
            end
          end
        end
        S_RX: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + CW'(1);
            // Dropping REN here refuses any beat beyond the N-th.
            if (wr_ptr == beats - CW'(1)) begin
              rx_ren <= 1'b0;
              state  <= S_PREP;
            end
          end
        end
        S_PREP: begin
          rd_ptr <= '0;
          tx_req <= 1'b1;
          tx_vld <= 1'b1;
          tx_len <= len_round;
          state  <= S_TX;
        end
        S_TX: begin
          if (xfer) begin
            rd_ptr <= rd_ptr_nxt;
            if (rd_ptr == beats - CW'(1)) begin
              tx_req <= 1'b0;
              tx_vld <= 1'b0;
              tx_len <= '0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chnl_tester.sv
// tb_chnl_tester: directed loopback transactions against chnl_tester (128-bit beats, 1024 deep).
// Table of {LEN, beats, TX_LEN, VALID duty, REN duty} records plus hand sequences for zero length and reset mid-RX.
// Expected data comes from the bench's own copy of each transmitted beat.
module tb_chnl_tester;

  localparam int DW = 128;

  logic          clk;
  logic          rst;
  logic          rx_clk;
  logic          rx;
  logic          rx_ack;
  logic          rx_last;
  logic [31:0]   rx_len;
  logic [30:0]   rx_off;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ren;
  logic          tx_clk;
  logic          tx;
  logic          tx_ack;
  logic          tx_last;
  logic [31:0]   tx_len;
  logic [30:0]   tx_off;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ren;

  int errors;
  int checks;

  logic [DW-1:0] src [1024];
  logic [DW-1:0] first_out;

  typedef struct {
    logic [31:0] len;
    int          n;
    logic [31:0] txlen;
    int          vduty;
    int          rduty;
  } vec_t;

  vec_t vecs [6];

  chnl_tester #(
    .C_PCI_DATA_WIDTH(DW),
    .C_DEPTH(1024),
    .C_ADDR_WIDTH(10)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .CHNL_RX_CLK(rx_clk),
    .CHNL_RX(rx),
    .CHNL_RX_ACK(rx_ack),
    .CHNL_RX_LAST(rx_last),
    .CHNL_RX_LEN(rx_len),
    .CHNL_RX_OFF(rx_off),
    .CHNL_RX_DATA(rx_data),
    .CHNL_RX_DATA_VALID(rx_valid),
    .CHNL_RX_DATA_REN(rx_ren),
    .CHNL_TX_CLK(tx_clk),
    .CHNL_TX(tx),
    .CHNL_TX_ACK(tx_ack),
    .CHNL_TX_LAST(tx_last),
    .CHNL_TX_LEN(tx_len),
    .CHNL_TX_OFF(tx_off),
    .CHNL_TX_DATA(tx_data),
    .CHNL_TX_DATA_VALID(tx_valid),
    .CHNL_TX_DATA_REN(tx_ren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected TX beat for a stored RX beat.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef CHNL_TESTER_INC_EN
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = d[i*32 +: 32] + 32'd1;
`endif
    return r;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) src[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ack"}, DW'(rx_ack), DW'(0));
    check({tag, "_rx_ren"}, DW'(rx_ren), DW'(0));
    check({tag, "_tx"}, DW'(tx), DW'(0));
    check({tag, "_tx_len"}, DW'(tx_len), DW'(0));
    check({tag, "_tx_valid"}, DW'(tx_valid), DW'(0));
    check({tag, "_tx_data"}, tx_data, DW'(0));
    check({tag, "_tx_last"}, DW'(tx_last), DW'(1));
    check({tag, "_tx_off"}, DW'(tx_off), DW'(0));
  endtask

  // One full RX-then-TX transaction, using src[0..n-1] as the RX beats.
  task automatic run_txn(input logic [31:0] len, input int n, input logic [31:0] txlen,
                         input int vduty, input int rduty);
    int  k;
    int  j;
    int  cyc;
    int  budget;
    bit  v;
    bit  r;
    bit  acc;
    bit  first;
    budget = n * 60 + 100;
    @(negedge clk);
    rx = 1'b1;
    rx_len = len;
    #1;
    check("rx_ack", DW'(rx_ack), DW'(1));
    @(posedge clk);
    k = 0;
    cyc = 0;
    first = 1'b1;
    while (k < n && cyc < budget) begin
      @(negedge clk);
      rx = 1'b0;
      if (first) check("rx_ren_up", DW'(rx_ren), DW'(1));
      first = 1'b0;
      v = ($urandom_range(99) < vduty);
      rx_valid = v;
      rx_data = src[k];
      acc = v && rx_ren;
      @(posedge clk);
      if (acc) k++;
      cyc++;
    end
    check("rx_beats", DW'(k), DW'(n));
    @(negedge clk);
    rx = 1'b0;
    rx_valid = 1'b1;
    rx_data = '1;
    check("rx_ren_drop", DW'(rx_ren), DW'(0));
    cyc = 0;
    while (!tx && cyc < 10) begin
      @(negedge clk);
      rx_valid = 1'b0;
      cyc++;
    end
    rx_valid = 1'b0;
    check("tx_seen", DW'(tx), DW'(1));
    if (!tx) return;
    check("tx_len", DW'(tx_len), DW'(txlen));
    check("tx_valid_pre_ack", DW'(tx_valid), DW'(1));
    tx_ack = 1'b1;
    j = 0;
    cyc = 0;
    first = 1'b1;
    while (j < n && cyc < budget) begin
      if (!first) begin
        @(negedge clk);
        tx_ack = 1'b0;
      end
      first = 1'b0;
      r = ($urandom_range(99) < rduty);
      tx_ren = r;
      if (r && tx_valid) begin
        if (j == 0) first_out = tx_data;
        check($sformatf("tx_beat%0d", j), tx_data, model(src[j]));
        j++;
      end
      @(posedge clk);
      cyc++;
    end
    check("tx_beats", DW'(j), DW'(n));
    @(negedge clk);
    tx_ren = 1'b0;
    tx_ack = 1'b0;
    check("tx_drop", DW'(tx), DW'(0));
    check("tx_valid_drop", DW'(tx_valid), DW'(0));
  endtask

  initial begin
    int zbad;
    errors = 0;
    checks = 0;
    first_out = '0;
    rst = 1'b1;
    rx = 1'b0;
    rx_last = 1'b1;
    rx_len = '0;
    rx_off = '0;
    rx_data = '0;
    rx_valid = 1'b0;
    tx_ack = 1'b0;
    tx_ren = 1'b0;

    // {LEN, beats, TX_LEN, VALID duty %, REN duty %}
    vecs[0] = '{32'd4096, 1024, 32'd4096, 50, 100};  // full buffer, VALID gaps
    vecs[1] = '{32'd256,  64,   32'd256,  100, 50};  // TX back-pressure
    vecs[2] = '{32'd5,    2,    32'd8,    100, 100}; // short, rounded up
    vecs[3] = '{32'd7,    2,    32'd8,    30,  30};  // second short transaction
    vecs[4] = '{32'd8000, 1024, 32'd8000, 100, 60};  // longer than buffer: clamped beats
    vecs[5] = '{32'd1,    1,    32'd4,    100, 100}; // single word

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    check("rx_clk_follows", DW'(rx_clk), DW'(0));
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      fill_random(vecs[t].n);
      run_txn(vecs[t].len, vecs[t].n, vecs[t].txlen, vecs[t].vduty, vecs[t].rduty);
    end

    // Zero length: acknowledged, but no REN and no TX follow.
    @(negedge clk);
    rx = 1'b1;
    rx_len = 32'd0;
    #1;
    check("zero_ack", DW'(rx_ack), DW'(1));
    @(posedge clk);
    zbad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx = 1'b0;
      if (rx_ren || tx || tx_valid) zbad++;
    end
    check("zero_idle", DW'(zbad), DW'(0));

    // Reset in the middle of RX after 100 beats.
    fill_random(1024);
    @(negedge clk);
    rx = 1'b1;
    rx_len = 32'd4096;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rx = 1'b0;
      rx_valid = 1'b1;
      rx_data = src[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrx_reset");
    @(negedge clk);
    rst = 1'b0;
    fill_random(64);
    run_txn(32'd256, 64, 32'd256, 100, 70);

`ifdef CHNL_TESTER_INC_EN
    src[0] = 128'h00000001_FFFFFFFF_00000000_7FFFFFFF;
    run_txn(32'd4, 1, 32'd4, 100, 100);
    check("inc_vector", first_out, 128'h00000002_00000000_00000001_80000000);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
